// File: rtl/lsu.sv
// lsu: load/store unit between the single-cycle datapath and a req/ack data bus.
// The core is held with stall while an access is in flight. The unit drives
// byte/half/word lane enables and sign- or zero-extends load data.
// Optional feature: define LSU_MISALIGN_TRAP_EN to abort misaligned half/word
// accesses without a bus transaction. They then return rdata=0 and fault=1.
module lsu #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memread,
  input  logic        memwrite,
  input  logic [1:0]  size,
  input  logic        lsigned,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        fault,
  output logic        m_req,
  output logic        m_we,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_be,
  input  logic        m_ack,
  input  logic [31:0] m_rdata
);

  localparam logic [7:0] TMO = 8'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t      state, state_n;
  logic [7:0]  cnt, cnt_n;
  logic [7:0]  cnt_inc;
  logic        access;
  logic        misalign;
  logic        stall_c;
  logic        issue;
  logic        trap;
  logic        fin_ok;
  logic        fin_tmo;
  logic [3:0]  be_c;
  logic [31:0] wdata_c;

  // Access attributes captured at issue, used to format the returning word
  logic        load_p1;
  logic [1:0]  size_p1;
  logic [1:0]  lane_p1;
  logic        sgn_p1;

  // Select the addressed lane of a bus word and extend it to 32 bits
  function automatic logic [31:0] fmt_load(input logic [31:0] w,
                                           input logic [1:0]  sz,
                                           input logic [1:0]  lane,
                                           input logic        sgn);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic [31:0]        r;
    b = w[{lane, 3'b000} +: 8];
    h = lane[1] ? w[31:16] : w[15:0];
    case (sz)
      2'b00:   r = sgn ? 32'(b) : {24'd0, b};
      2'b01:   r = sgn ? 32'(h) : {16'd0, h};
      default: r = w;
    endcase
    return r;
  endfunction

  assign access  = memread | memwrite;
  assign cnt_inc = cnt + 8'd1;

`ifdef LSU_MISALIGN_TRAP_EN
  assign misalign = ((size == 2'b01) && addr[0]) ||
                    (size[1] && (addr[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  // Byte-enable and store-data lane replication for the incoming access
  always_comb begin
    be_c    = 4'b1111;
    wdata_c = wdata;
    case (size)
      2'b00: begin
        be_c    = 4'b0001 << addr[1:0];
        wdata_c = {4{wdata[7:0]}};
      end
      2'b01: begin
        be_c    = 4'b0011 << {addr[1], 1'b0};
        wdata_c = {2{wdata[15:0]}};
      end
      default: begin
        be_c    = 4'b1111;
        wdata_c = wdata;
      end
    endcase
  end

  // Next-state, counter and transaction strobes
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    stall_c = 1'b0;
    issue   = 1'b0;
    trap    = 1'b0;
    fin_ok  = 1'b0;
    fin_tmo = 1'b0;
    case (state)
      IDLE: begin
        if (access) begin
          stall_c = 1'b1;
          cnt_n   = 8'd0;
          if (misalign) begin
            trap    = 1'b1;
            state_n = DONE;
          end else begin
            issue   = 1'b1;
            state_n = REQ;
          end
        end
      end
      REQ: begin
        stall_c = 1'b1;
        cnt_n   = cnt_inc;
        if (m_ack) begin
          fin_ok  = 1'b1;
          state_n = DONE;
        end else if (cnt_inc == TMO) begin
          fin_tmo = 1'b1;
          state_n = DONE;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // The core is never stalled while held in reset
  assign stall = stall_c & reset;

  // FSM state and REQ cycle counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= 8'd0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // Bus request: raised at issue, dropped on ack or timeout
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_req   <= 1'b0;
      m_we    <= 1'b0;
      m_addr  <= 32'd0;
      m_wdata <= 32'd0;
      m_be    <= 4'd0;
    end else begin
      if (issue) begin
        m_req   <= 1'b1;
        m_we    <= memwrite;
        m_addr  <= {addr[31:2], 2'b00};
        m_wdata <= wdata_c;
        m_be    <= be_c;
      end else if (fin_ok || fin_tmo) begin
        m_req   <= 1'b0;
      end
    end
  end

  // Load result and abort pulse, both visible in DONE
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata <= 32'd0;
      fault <= 1'b0;
    end else begin
      fault <= fin_tmo | trap;
      if (fin_tmo || trap) begin
        rdata <= 32'd0;
      end else if (fin_ok && load_p1) begin
        rdata <= fmt_load(m_rdata, size_p1, lane_p1, sgn_p1);
      end
    end
  end

  // Access attributes, only consumed while the matching request is in flight
  always_ff @(posedge clk) begin
    if (issue) begin
      load_p1 <= ~memwrite;
      size_p1 <= size;
      lane_p1 <= addr[1:0];
      sgn_p1  <= lsigned;
    end
  end

endmodule
